svmod_break_ctrl: RTL and testbench

Break sequencer for the supervisor-mode / peripheral-stop signals used by OCD and ICE emulation. It converts a break request from the debug logic into an ordered sequence. The sequence wakes the CPU from standby, asserts the supervisor-mode stop, stops timer and serial peripherals after a programmable delay, and waits for the CPU's supervisor-mode acknowledge. It also unwinds the sequence in reverse order on run request and supports open break, where the peripherals keep running. It drives the ICE-side inputs (SVMODI, SVMODIPERI1, SVMODIPERI2, SVMODOPBRK, STBRELESV) of the SV mode OR-merge block.

---
 rtl/svmod_break_ctrl_if.sv | 26 ++
 rtl/svmod_break_ctrl.sv | 59 +++++
 tb/tb_svmod_break_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/svmod_break_ctrl_if.sv
// svmod_break_ctrl_if: debug-side break request/acknowledge bundle and ICE-side stop outputs
interface svmod_break_ctrl_if;
  logic brkreq;
  logic runreq;
  logic opbrken;
  logic peri0stpen;
  logic peri1stpen;
  logic stby;
  logic monsvmod;
  logic errclr;
  logic svmodi;
  logic svmodiperi1;
  logic svmodiperi2;
  logic svmodopbrk;
  logic stbrelesv;
  logic brkact;
  logic tmoerr;
  modport master (
    output brkreq, runreq, opbrken, peri0stpen, peri1stpen, stby, monsvmod, errclr,
    input  svmodi, svmodiperi1, svmodiperi2, svmodopbrk, stbrelesv, brkact, tmoerr
  );
  modport slave (
    input  brkreq, runreq, opbrken, peri0stpen, peri1stpen, stby, monsvmod, errclr,
    output svmodi, svmodiperi1, svmodiperi2, svmodopbrk, stbrelesv, brkact, tmoerr
  );
endinterface

// File: rtl/svmod_break_ctrl.sv
// svmod_break_ctrl: sequences break entry/exit into ordered supervisor-mode and peripheral-stop requests
module svmod_break_ctrl #(
  parameter int PERI_DLY = 2,
  parameter int ACK_TMO  = 255
) (
  input logic clk,
  input logic rst,
  svmod_break_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAKE    = 3'd1;
  localparam logic [2:0] ENTER   = 3'd2;
  localparam logic [2:0] WAITACK = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;
  localparam logic [2:0] EXIT    = 3'd5;
  localparam logic [2:0] OPEN    = 3'd6;
  localparam logic [3:0] DLY      = 4'(PERI_DLY);
  localparam logic [9:0] TMO_LAST = 10'(ACK_TMO - 1);
  logic [2:0] state, nxt;
  logic [3:0] dly;
  logic [9:0] tmo;
  logic       tmo_hit;
  logic       held;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.brkreq ? (bus.opbrken ? OPEN : bus.stby ? WAKE : ENTER) : IDLE;
      WAKE:    nxt = ENTER;
      ENTER:   nxt = (dly == 4'd1) ? WAITACK : ENTER;
      WAITACK: nxt = bus.runreq ? EXIT : (bus.monsvmod || tmo == TMO_LAST) ? HALT : WAITACK;
      HALT:    nxt = bus.runreq ? EXIT : HALT;
      EXIT:    nxt = (dly == 4'd1) ? IDLE : EXIT;
      OPEN:    nxt = bus.runreq ? IDLE : OPEN;
      default: nxt = IDLE;
    endcase
  end
  // run request and acknowledge both outrank the timeout in the same cycle
  assign tmo_hit = (state == WAITACK) && !bus.runreq && !bus.monsvmod && (tmo == TMO_LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dly    <= 4'd0;
      tmo    <= 10'd0;
      bus.tmoerr <= 1'b0;
    end else begin
      state  <= nxt;
      dly    <= (nxt != state) ? DLY : (dly != 4'd0) ? dly - 4'd1 : dly;
      tmo    <= (state == WAITACK) ? tmo + 10'd1 : 10'd0;
      bus.tmoerr <= tmo_hit | (bus.tmoerr & ~bus.errclr);
    end
  end
  assign held            = (state == WAITACK) || (state == HALT);
  assign bus.svmodi      = (state == ENTER) || held || (state == EXIT);
  assign bus.svmodiperi1 = held & bus.peri1stpen;
  assign bus.svmodiperi2 = held & bus.peri0stpen;
  assign bus.svmodopbrk  = (state == OPEN);
  assign bus.stbrelesv   = (state == WAKE);
  assign bus.brkact      = (state == HALT) || (state == OPEN);
endmodule

// File: tb/tb_svmod_break_ctrl.sv
// tb_svmod_break_ctrl: randomized break scenarios against a timeline model with a queued scoreboard
module tb_svmod_break_ctrl;
  localparam int PD = 2;
  localparam int AT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  svmod_break_ctrl_if bus();
  svmod_break_ctrl #(.PERI_DLY(PD), .ACK_TMO(AT)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [6:0] q[$];
  logic [6:0] e_m;
  logic [6:0] got;
  logic etmo = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  assign got = {bus.svmodi, bus.svmodiperi1, bus.svmodiperi2, bus.svmodopbrk, bus.stbrelesv, bus.brkact, bus.tmoerr};
  // monitor: one expected output vector per cycle, {svmodi,peri1,peri2,opbrk,stbrel,brkact,tmoerr}
  always @(negedge clk) begin
    cyc_n++;
    if (q.size() > 0) begin
      e_m = q.pop_front();
      n_chk++;
      if (got !== e_m) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc_n, got, e_m);
      end
      n_chk++;
      if ((bus.svmodiperi1 === 1'b1 || bus.svmodiperi2 === 1'b1) && bus.svmodi !== 1'b1) begin
        n_fail++;
        $display("FAIL peri_without_svmodi cyc=%0d got=%b exp svmodi=1", cyc_n, got);
      end
      n_chk++;
      if (bus.svmodopbrk === 1'b1 && bus.svmodi === 1'b1) begin
        n_fail++;
        $display("FAIL opbrk_with_svmodi cyc=%0d got=%b exp not both", cyc_n, got);
      end
    end
  end
  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic bit rc();
    return $urandom_range(0, 7) == 0;
  endfunction
  function automatic logic [5:0] ex(input bit svi, p1, p2, ob, sr, ac);
    return {svi, p1, p2, ob, sr, ac};
  endfunction
  task automatic cyc(input bit r, b, ru, ob, sb, m, c, tev, input logic [5:0] e6);
    q.push_back({e6, etmo});
    rst = r;
    bus.brkreq = b;
    bus.runreq = ru;
    bus.opbrken = ob;
    bus.stby = sb;
    bus.monsvmod = m;
    bus.errclr = c;
    @(posedge clk);
    #1;
    etmo = r ? 1'b0 : tev ? 1'b1 : c ? 1'b0 : etmo;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, rb(), rb(), rb(), rb(), rc(), 0, ex(0, 0, 0, 0, 0, 0));
  endtask
  // rst_pt: 0 none, 1 reset in first WAITACK cycle, 2 reset in first EXIT cycle
  task automatic brk_seq(input bit sb, p0, p1, input int ack_at, run_wait, halt_len,
                         input bit clr_t, input int rst_pt, input bit chain);
    bit halted, tev;
    bus.peri0stpen = p0;
    bus.peri1stpen = p1;
    cyc(0, 1, rb(), 0, sb, rb(), rc(), 0, ex(0, 0, 0, 0, 0, 0));
    if (sb) cyc(0, rb(), rb(), rb(), rb(), rb(), rc(), 0, ex(0, 0, 0, 0, 1, 0));
    for (int i = 0; i < PD; i++) cyc(0, rb(), rb(), rb(), rb(), rb(), rc(), 0, ex(1, 0, 0, 0, 0, 0));
    halted = 0;
    for (int i = 0; i < AT; i++) begin
      if (rst_pt == 1) begin
        cyc(1, rb(), 0, 0, 0, 0, 0, 0, ex(1, p1, p0, 0, 0, 0));
        idle(1);
        return;
      end
      tev = (i == AT - 1) && (i != run_wait) && (i < ack_at);
      cyc(0, rb(), i == run_wait, rb(), rb(), i >= ack_at, tev ? clr_t : rc(), tev, ex(1, p1, p0, 0, 0, 0));
      if (i == run_wait) break;
      if (i >= ack_at || tev) begin
        halted = 1;
        break;
      end
    end
    if (halted)
      for (int i = 0; i < halt_len; i++)
        cyc(0, rb(), i == halt_len - 1, rb(), rb(), rb(), rc(), 0, ex(1, p1, p0, 0, 0, 1));
    for (int i = 0; i < PD; i++) begin
      if (rst_pt == 2) begin
        cyc(1, rb(), 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0));
        idle(1);
        return;
      end
      cyc(0, rb(), rb(), rb(), rb(), rb(), rc(), 0, ex(1, 0, 0, 0, 0, 0));
    end
    if (!chain) idle(1);
  endtask
  task automatic open_seq(input int len, input bit run0);
    cyc(0, 1, run0, 1, rb(), rb(), rc(), 0, ex(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < len; i++) cyc(0, rb(), i == len - 1, rb(), rb(), rb(), rc(), 0, ex(0, 0, 0, 1, 0, 1));
    idle(1);
  endtask
  initial begin
    int aa, rw, rw_max;
    {bus.brkreq, bus.runreq, bus.opbrken, bus.peri0stpen, bus.peri1stpen, bus.stby, bus.monsvmod, bus.errclr} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    idle(2);
    brk_seq(0, 1, 1, 2, -1, 15, 0, 0, 0);
    brk_seq(1, 1, 1, 1, -1, 3, 0, 0, 0);
    brk_seq(0, 1, 0, 20, -1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    brk_seq(0, 0, 1, 20, -1, 2, 1, 0, 0);
    idle(2);
    open_seq(3, 0);
    open_seq(2, 1);
    brk_seq(0, 1, 1, 3, 1, 1, 0, 0, 0);
    brk_seq(0, 1, 1, 5, -1, 1, 0, 1, 0);
    brk_seq(0, 1, 1, 1, -1, 2, 0, 2, 0);
    brk_seq(0, 1, 1, 0, -1, 1, 0, 0, 1);
    brk_seq(1, 0, 0, 2, -1, 2, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) open_seq($urandom_range(1, 4), rb());
      else begin
        aa = $urandom_range(0, AT + 1);
        rw_max = (aa < AT - 1) ? aa : AT - 1;
        rw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rw_max) : -1;
        brk_seq(rb(), rb(), rb(), aa, rw, $urandom_range(1, 4), rb(), 0, rb());
      end
    end
    idle(2);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
